// File: rtl/fetch_unit_pkg.sv
// Shared RISC-V fetch/decode definitions: widths, reset PC, NOP encoding, opcodes,
// the {pc, instruction} queue entry and small PC helpers.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] xlen_t;

  localparam xlen_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam xlen_t INSTR_NOP        = 32'h0000_0013;

  // Base-ISA major opcodes, shared with decode and the immediate generator.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    xlen_t pc;
    xlen_t instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Sequential fetch address; wraps modulo 2^XLEN.
  function automatic xlen_t pc_next(input xlen_t pc);
    return pc + xlen_t'(4);
  endfunction

  // Word-align a redirect target by clearing the byte-offset bits.
  function automatic xlen_t pc_align(input xlen_t pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect and the
// {pc, instruction} handshake toward decode. master = fetch unit, slave = its environment.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  xlen_t imem_req_addr;
  logic  imem_resp_valid;
  xlen_t imem_resp_data;
  logic  redirect_valid;
  xlen_t redirect_pc;
  logic  out_valid;
  logic  out_ready;
  xlen_t out_pc;
  xlen_t out_instruction;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instruction,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instruction,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with push/pop/flush and an occupancy count; flush wins over push and pop.
// Used both for the {pc, instruction} output queue and the per-request PC tag FIFO.
module fetch_queue #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push = i_push & ~i_flush & (~w_full | i_pop);
  assign w_pop  = i_pop  & ~i_flush & ~o_empty;

  // NOTE: the storage array has no reset; r_count alone decides which entries are live,
  // so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited in-order memory requests, wrong-path drop
// after redirects, and a registered {pc, instruction} queue toward decode.
// Optional FETCH_PERF_EN adds perf_fetched / perf_squashed event counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter  xlen_t RESET_PC    = RESET_PC_DEFAULT,
  parameter  int    QUEUE_DEPTH = 2,
  localparam int    CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_squashed
`endif
);

  xlen_t            r_pc;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [CNT_W-1:0] w_inflight;
  logic [CNT_W-1:0] w_q_count;
  logic [CNT_W:0]   w_occupancy;
  logic             w_credit;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_tag_empty;
  xlen_t            w_tag_pc;
  logic             w_resp;
  logic             w_dropping;
  logic             w_push;
  logic             w_q_empty;
  logic             w_out_valid;
  logic             w_out_fire;
  xlen_t            w_redirect_pc;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head_entry;
  logic [ENTRY_W-1:0] w_head_raw;

  // Every in-flight request owns a tag entry, so the tag FIFO count is the in-flight count
  // (live plus still-to-be-dropped requests).
  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (XLEN)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_req_fire),
    .i_pop   (w_resp),
    .i_flush (1'b0),
    .i_data  (r_pc),
    .o_data  (w_tag_pc),
    .o_count (w_inflight),
    .o_empty (w_tag_empty)
  );

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_out_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_out_fire),
    .i_flush (bus.redirect_valid),
    .i_data  (w_push_entry),
    .o_data  (w_head_raw),
    .o_count (w_q_count),
    .o_empty (w_q_empty)
  );

  // Counting doomed requests in the credit keeps the tag FIFO from ever overflowing.
  assign w_occupancy = {1'b0, w_inflight} + {1'b0, w_q_count};
  assign w_credit    = (w_occupancy < (CNT_W + 1)'(QUEUE_DEPTH));
  assign w_req_valid = ~reset & w_credit & ~bus.redirect_valid;
  assign w_req_fire  = w_req_valid & bus.imem_req_ready;

  assign w_resp     = bus.imem_resp_valid & ~w_tag_empty;
  assign w_dropping = (r_drop_cnt != '0);
  assign w_push     = w_resp & ~bus.redirect_valid & ~w_dropping;

  assign w_push_entry  = '{pc: w_tag_pc, instr: bus.imem_resp_data};
  assign w_head_entry  = fetch_entry_t'(w_head_raw);
  assign w_redirect_pc = pc_align(bus.redirect_pc);

  assign w_out_valid = ~w_q_empty & ~bus.redirect_valid;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  assign bus.imem_req_valid  = w_req_valid;
  assign bus.imem_req_addr   = r_pc;
  assign bus.out_valid       = w_out_valid;
  assign bus.out_pc          = w_head_entry.pc;
  assign bus.out_instruction = w_head_entry.instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      r_pc       <= w_redirect_pc;
      // drop_cnt + live outstanding == all in flight; the response arriving now is discarded
      // directly, so only the remaining in-flight words need dropping later.
      r_drop_cnt <= w_inflight - CNT_W'(w_resp);
    end else begin
      if (w_req_fire) begin
        r_pc <= pc_next(r_pc);
      end
      if (w_resp && w_dropping) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_squashed;

  // Squashed = dropped responses plus queue entries thrown away by a redirect flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched  <= '0;
      r_perf_squashed <= '0;
    end else begin
      r_perf_fetched <= r_perf_fetched + 32'(w_out_fire);
      if (bus.redirect_valid) begin
        r_perf_squashed <= r_perf_squashed + 32'(w_q_count) + 32'(w_resp);
      end else begin
        r_perf_squashed <= r_perf_squashed + 32'(w_resp & w_dropping);
      end
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_squashed = r_perf_squashed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural in-order memory with programmable latency,
// a delivery log toward decode, and immediate assertions at each comparison point.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if ifc ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } dlv_t;

  pend_t pend[$];
  dlv_t  dlv[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int lat     = 1;
  int n_req   = 0;

  logic        obs_req_valid;
  logic [31:0] obs_req_addr;
  logic        obs_out_valid;
  logic [31:0] obs_out_pc;
  logic [31:0] obs_out_instr;

  // Memory contents: every address holds a distinct, easily recognised word.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0013;
  endfunction

  function automatic logic [31:0] dlv_pc(input int i);
    return (i < dlv.size()) ? dlv[i].pc : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dlv_instr(input int i);
    return (i < dlv.size()) ? dlv[i].instr : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle, entered and left at the falling edge with this cycle's inputs applied.
  task automatic tick();
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_data  = 32'h0;
    if (reset) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      ifc.imem_resp_valid = 1'b1;
      ifc.imem_resp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    #1;
    obs_req_valid = ifc.imem_req_valid;
    obs_req_addr  = ifc.imem_req_addr;
    obs_out_valid = ifc.out_valid;
    obs_out_pc    = ifc.out_pc;
    obs_out_instr = ifc.out_instruction;
    if (!reset && ifc.imem_req_valid && ifc.imem_req_ready) begin
      pend.push_back('{addr: ifc.imem_req_addr, due: cyc + lat});
      n_req++;
    end
    if (ifc.out_valid && ifc.out_ready) begin
      dlv.push_back('{pc: ifc.out_pc, instr: ifc.out_instruction});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input string tag);
    reset              = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'h0;
    ifc.out_ready      = 1'b1;
    tick();
    tick();
    check({tag, "_rst_req_valid"}, 32'(obs_req_valid), 32'd0);
    check({tag, "_rst_out_valid"}, 32'(obs_out_valid), 32'd0);
    reset = 1'b0;
    pend.delete();
    dlv.delete();
    cyc   = 0;
    n_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.imem_req_ready  = 1'b1;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_data  = 32'h0;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_pc     = 32'h0;
    ifc.out_ready       = 1'b1;
    @(negedge clk);

    // 1: sequential fetch, 1-cycle memory, decode always ready.
    lat = 1;
    do_reset("t1");
    tick();
    check("t1_c0_req_valid", 32'(obs_req_valid), 32'd1);
    check("t1_c0_addr", obs_req_addr, 32'h0000_0000);
    check("t1_c0_out_valid", 32'(obs_out_valid), 32'd0);
    tick();
    check("t1_c1_addr", obs_req_addr, 32'h0000_0004);
    check("t1_c1_out_valid", 32'(obs_out_valid), 32'd0);
    tick();
    check("t1_c2_out_valid", 32'(obs_out_valid), 32'd1);
    check("t1_c2_out_pc", obs_out_pc, 32'h0000_0000);
    check("t1_c2_out_instr", obs_out_instr, mem_word(32'h0));
    repeat (12) tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_dlv%0d_pc", i), dlv_pc(i), 32'(4 * i));
      check($sformatf("t1_dlv%0d_instr", i), dlv_instr(i), mem_word(32'(4 * i)));
    end

    // 2: decode stalled for 10 cycles; credit caps requests at the queue depth.
    do_reset("t2");
    ifc.out_ready = 1'b0;
    repeat (10) tick();
    check("t2_req_count", 32'(n_req), 32'd2);
    check("t2_stall_req_valid", 32'(obs_req_valid), 32'd0);
    check("t2_stall_out_valid", 32'(obs_out_valid), 32'd1);
    check("t2_stall_head_pc", obs_out_pc, 32'h0000_0000);
    check("t2_stall_dlv_count", 32'(dlv.size()), 32'd0);
    ifc.out_ready = 1'b1;
    repeat (8) tick();
    check("t2_dlv0_pc", dlv_pc(0), 32'h0000_0000);
    check("t2_dlv1_pc", dlv_pc(1), 32'h0000_0004);
    check("t2_dlv1_instr", dlv_instr(1), mem_word(32'h4));
    check("t2_dlv2_pc", dlv_pc(2), 32'h0000_0008);

    // 3: latency 3, redirect with two requests in flight; both wrong-path words dropped.
    lat = 3;
    do_reset("t3");
    tick();
    tick();
    check("t3_inflight_reqs", 32'(n_req), 32'd2);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h0000_0100;
    tick();
    check("t3_redir_req_valid", 32'(obs_req_valid), 32'd0);
    check("t3_redir_out_valid", 32'(obs_out_valid), 32'd0);
    ifc.redirect_valid = 1'b0;
    repeat (14) tick();
    check("t3_dlv0_pc", dlv_pc(0), 32'h0000_0100);
    check("t3_dlv0_instr", dlv_instr(0), mem_word(32'h100));
    check("t3_dlv1_pc", dlv_pc(1), 32'h0000_0104);

    // 4: redirect coincides with a response and with out_ready; misaligned target.
    lat = 1;
    do_reset("t4");
    tick();
    tick();
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h0000_0043;
    tick();
    check("t4_redir_out_valid", 32'(obs_out_valid), 32'd0);
    check("t4_redir_no_pop", 32'(dlv.size()), 32'd0);
    ifc.redirect_valid = 1'b0;
    tick();
    check("t4_aligned_addr", obs_req_addr, 32'h0000_0040);
    repeat (6) tick();
    check("t4_dlv0_pc", dlv_pc(0), 32'h0000_0040);
    check("t4_dlv0_instr", dlv_instr(0), mem_word(32'h40));

    // 5: back-to-back redirects; only the second target's path is delivered.
    lat = 3;
    do_reset("t5");
    tick();
    tick();
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h0000_0200;
    tick();
    ifc.redirect_pc    = 32'h0000_0300;
    tick();
    ifc.redirect_valid = 1'b0;
    repeat (14) tick();
    check("t5_dlv0_pc", dlv_pc(0), 32'h0000_0300);
    check("t5_dlv0_instr", dlv_instr(0), mem_word(32'h300));
    check("t5_dlv1_pc", dlv_pc(1), 32'h0000_0304);

    // 6: fetch at the top of the address space wraps to zero.
    lat = 1;
    do_reset("t6");
    tick();
    tick();
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    ifc.redirect_valid = 1'b0;
    tick();
    check("t6_addr_top", obs_req_addr, 32'hFFFF_FFFC);
    tick();
    check("t6_addr_wrap_valid", 32'(obs_req_valid), 32'd1);
    check("t6_addr_wrap", obs_req_addr, 32'h0000_0000);
    repeat (6) tick();
    check("t6_dlv0_pc", dlv_pc(0), 32'hFFFF_FFFC);
    check("t6_dlv0_instr", dlv_instr(0), mem_word(32'hFFFF_FFFC));
    check("t6_dlv1_pc", dlv_pc(1), 32'h0000_0000);
`ifdef FETCH_PERF_EN
    check("t6_perf_fetched", perf_fetched, 32'(dlv.size()));
    check("t6_perf_squashed", perf_squashed, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
